// File: rtl/dispatch_checker_if.sv
// dispatch_checker_if: the dispatch-stage signals observed by dispatch_checker.
// The core side (or a bench) drives through the master modport; the checker
// listens through the slave modport.
interface dispatch_checker_if #(
  parameter int N         = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int CKPTS     = 4
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PR_W  = $clog2(PHYS_REGS);
  localparam int AR_W  = $clog2(ARCH_REGS);
  localparam int CK_W  = (CKPTS > 1) ? $clog2(CKPTS) : 1;

  logic [CNT_W-1:0]          inst_valid;
  logic [CNT_W-1:0]          rs_spots;
  logic [CNT_W-1:0]          rob_spots;
  logic [CNT_W-1:0]          num_issuing;
  logic [CNT_W-1:0]          num_dispatched;
  logic [N-1:0]              dest_valid;
  logic [N-1:0]              is_branch;
  logic [N*AR_W-1:0]         dest_arch;
  logic [N*PR_W-1:0]         regs_to_use;
  logic                      restore_valid;
  logic [CK_W-1:0]           restore_idx;
  logic                      resolve_valid;
  logic [CK_W-1:0]           resolve_idx;
  logic [N-1:0]              retire_valid;
  logic [N*PR_W-1:0]         retire_reg;
  logic [ARCH_REGS*PR_W-1:0] dut_map_table;
  logic [PHYS_REGS-1:0]      dut_free_list;

  modport master (
    output inst_valid, rs_spots, rob_spots, num_issuing, num_dispatched,
    output dest_valid, is_branch, dest_arch, regs_to_use,
    output restore_valid, restore_idx, resolve_valid, resolve_idx,
    output retire_valid, retire_reg, dut_map_table, dut_free_list
  );

  modport slave (
    input inst_valid, rs_spots, rob_spots, num_issuing, num_dispatched,
    input dest_valid, is_branch, dest_arch, regs_to_use,
    input restore_valid, restore_idx, resolve_valid, resolve_idx,
    input retire_valid, retire_reg, dut_map_table, dut_free_list
  );
endinterface

// File: rtl/dispatch_checker.sv
// dispatch_checker: shadow rename state (map table, free list, branch
// checkpoints) for the N-way R10K dispatch stage. Recomputes the dispatch
// count, tracks allocation/retire/branch activity, and compares the DUT's
// registered map table and free list against the shadow every cycle.
// err bits: {ckpt_overflow, bad_ckpt, double_free, map, free_list,
//            double_alloc, num_dispatched}.
// Optional macro DISPATCH_CHECKER_FATAL_EN: report the flagged bit and lane
// and stop simulation at the offending edge. Without it errors are only
// flagged and counted; the synthesizable logic is the same either way.
module dispatch_checker #(
  parameter int N         = 2,
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int CKPTS     = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  dispatch_checker_if.slave    bus,
  output logic [6:0]           err,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic [CKPTS-1:0]     ckpt_valid
);
  localparam int CNT_W = $clog2(N + 1);
  localparam int PR_W  = $clog2(PHYS_REGS);
  localparam int AR_W  = $clog2(ARCH_REGS);
  localparam int CK_W  = (CKPTS > 1) ? $clog2(CKPTS) : 1;

  localparam logic [CNT_W:0]     N_EXT   = (CNT_W + 1)'(N);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  localparam int E_CNT   = 0;
  localparam int E_ALLOC = 1;
  localparam int E_FREE  = 2;
  localparam int E_MAP   = 3;
  localparam int E_DFREE = 4;
  localparam int E_CKPT  = 5;
  localparam int E_OVF   = 6;

  typedef logic [ARCH_REGS-1:0][PR_W-1:0] map_t;
  typedef logic [PHYS_REGS-1:0]           free_t;
  typedef logic [CKPTS-1:0]               mask_t;

  // Architectural register i starts out mapped to physical register i.
  function automatic map_t identity_map();
    map_t m;
    for (int i = 0; i < ARCH_REGS; i++) begin
      m[i] = PR_W'(i);
    end
    return m;
  endfunction

  // Every physical register above the architectural set starts out free.
  function automatic free_t reset_free();
    free_t f;
    for (int p = 0; p < PHYS_REGS; p++) begin
      f[p] = (p >= ARCH_REGS);
    end
    return f;
  endfunction

  // Shadow state
  map_t                  map_r,   map_s;
  free_t                 free_r,  free_s;
  mask_t                 ck_valid_r, vld_s;
  mask_t                 ck_older_r [CKPTS];
  mask_t                 older_s    [CKPTS];
  map_t                  ck_map_r   [CKPTS];
  map_t                  ck_map_s   [CKPTS];
  free_t                 ck_free_r  [CKPTS];
  free_t                 ck_free_s  [CKPTS];
  logic [6:0]            err_r,  err_s;
  logic [ERR_CNT_W-1:0]  cnt_r,  cnt_s;
  logic                  first_r;

  // Combinational scratch
  logic [CNT_W:0]        sum_s;
  logic [CNT_W:0]        exp_s;
  mask_t                 taken_s;
  mask_t                 kill_s;
  logic                  found_s;
  logic [CK_W-1:0]       slot_s;
  logic [PR_W-1:0]       preg_s;
  logic [AR_W-1:0]       areg_s;
`ifdef DISPATCH_CHECKER_FATAL_EN
  int                    err_lane_s;
`endif

  // Next shadow state and error flags for this cycle's events.
  always_comb begin
    map_s     = map_r;
    free_s    = free_r;
    vld_s     = ck_valid_r;
    older_s   = ck_older_r;
    ck_map_s  = ck_map_r;
    ck_free_s = ck_free_r;
    err_s     = 7'd0;
    taken_s   = ck_valid_r;
    kill_s    = '0;
    found_s   = 1'b0;
    slot_s    = '0;
    preg_s    = '0;
    areg_s    = '0;
`ifdef DISPATCH_CHECKER_FATAL_EN
    err_lane_s = -1;
`endif

    // Expected dispatch count: the sum is one bit wider so it cannot wrap.
    sum_s = {1'b0, bus.rs_spots} + {1'b0, bus.num_issuing};
    exp_s = ({1'b0, bus.rob_spots}  < sum_s) ? {1'b0, bus.rob_spots}  : sum_s;
    exp_s = ({1'b0, bus.inst_valid} < exp_s) ? {1'b0, bus.inst_valid} : exp_s;
    exp_s = (exp_s > N_EXT) ? N_EXT : exp_s;
    if (bus.restore_valid) begin
      exp_s = '0;
    end else begin
      exp_s = exp_s;
    end
    err_s[E_CNT] = (exp_s != {1'b0, bus.num_dispatched});

    if (bus.restore_valid) begin
      // A squash wins over dispatch; a stale index leaves the shadow untouched.
      if (ck_valid_r[bus.restore_idx]) begin
        map_s  = ck_map_r[bus.restore_idx];
        free_s = ck_free_r[bus.restore_idx];
      end else begin
        err_s[E_CKPT] = 1'b1;
      end
      kill_s[bus.restore_idx] = 1'b1;
      for (int k = 0; k < CKPTS; k++) begin
        kill_s[k] = kill_s[k] | ck_older_r[k][bus.restore_idx];
      end
      vld_s = vld_s & ~kill_s;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (i < int'(bus.num_dispatched)) begin
          if (bus.dest_valid[i]) begin
            preg_s = bus.regs_to_use[i*PR_W +: PR_W];
            areg_s = bus.dest_arch[i*AR_W +: AR_W];
            if (!free_s[preg_s]) begin
              err_s[E_ALLOC] = 1'b1;
`ifdef DISPATCH_CHECKER_FATAL_EN
              err_lane_s = i;
`endif
            end else begin
              err_s[E_ALLOC] = err_s[E_ALLOC];
            end
            free_s[preg_s] = 1'b0;
            map_s[areg_s]  = preg_s;
          end else begin
            preg_s = preg_s;
          end
          if (bus.is_branch[i]) begin
            // Slots freed by a resolve this cycle are not reusable until next cycle.
            found_s = 1'b0;
            slot_s  = '0;
            for (int k = CKPTS - 1; k >= 0; k--) begin
              if (!taken_s[k]) begin
                found_s = 1'b1;
                slot_s  = CK_W'(k);
              end else begin
                found_s = found_s;
              end
            end
            if (found_s) begin
              vld_s[slot_s]     = 1'b1;
              older_s[slot_s]   = taken_s;
              ck_map_s[slot_s]  = map_s;
              ck_free_s[slot_s] = free_s;
              taken_s[slot_s]   = 1'b1;
            end else begin
              err_s[E_OVF] = 1'b1;
`ifdef DISPATCH_CHECKER_FATAL_EN
              err_lane_s = i;
`endif
            end
          end else begin
            found_s = found_s;
          end
        end else begin
          preg_s = preg_s;
        end
      end
    end

    // Correctly predicted branch: release its slot unless it is being squashed.
    if (bus.resolve_valid && !(bus.restore_valid && (bus.resolve_idx == bus.restore_idx))) begin
      if (!ck_valid_r[bus.resolve_idx]) begin
        err_s[E_CKPT] = 1'b1;
      end else begin
        err_s[E_CKPT] = err_s[E_CKPT];
      end
      vld_s[bus.resolve_idx] = 1'b0;
      for (int k = 0; k < CKPTS; k++) begin
        older_s[k][bus.resolve_idx] = 1'b0;
      end
    end else begin
      vld_s = vld_s;
    end

    // Retired registers return to the live free list and every live snapshot.
    for (int i = 0; i < N; i++) begin
      if (bus.retire_valid[i]) begin
        preg_s = bus.retire_reg[i*PR_W +: PR_W];
        if (free_s[preg_s]) begin
          err_s[E_DFREE] = 1'b1;
`ifdef DISPATCH_CHECKER_FATAL_EN
          err_lane_s = i;
`endif
        end else begin
          err_s[E_DFREE] = err_s[E_DFREE];
        end
        free_s[preg_s] = 1'b1;
        for (int k = 0; k < CKPTS; k++) begin
          if (vld_s[k]) begin
            ck_free_s[k][preg_s] = 1'b1;
          end else begin
            ck_free_s[k] = ck_free_s[k];
          end
        end
      end else begin
        preg_s = preg_s;
      end
    end

    // DUT registered state against the shadow as of the previous edge.
    if (!first_r) begin
      err_s[E_MAP]  = (bus.dut_map_table != map_r);
      err_s[E_FREE] = (bus.dut_free_list != free_r);
    end else begin
      err_s[E_MAP]  = 1'b0;
      err_s[E_FREE] = 1'b0;
    end

    if ((err_s != 7'd0) && (cnt_r != CNT_MAX)) begin
      cnt_s = cnt_r + ERR_CNT_W'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Shadow state, error pulses and saturating counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      map_r      <= identity_map();
      free_r     <= reset_free();
      ck_valid_r <= '0;
      for (int k = 0; k < CKPTS; k++) begin
        ck_older_r[k] <= '0;
        ck_map_r[k]   <= identity_map();
        ck_free_r[k]  <= reset_free();
      end
      err_r   <= 7'd0;
      cnt_r   <= '0;
      first_r <= 1'b1;
    end else begin
      map_r      <= map_s;
      free_r     <= free_s;
      ck_valid_r <= vld_s;
      for (int k = 0; k < CKPTS; k++) begin
        ck_older_r[k] <= older_s[k];
        ck_map_r[k]   <= ck_map_s[k];
        ck_free_r[k]  <= ck_free_s[k];
      end
      err_r   <= err_s;
      cnt_r   <= cnt_s;
      first_r <= 1'b0;
    end
  end

  assign err         = err_r;
  assign error_count = cnt_r;
  assign ckpt_valid  = ck_valid_r;

`ifdef DISPATCH_CHECKER_FATAL_EN
  function automatic string err_name(input int b);
    case (b)
      0:       return "num_dispatched";
      1:       return "double_alloc";
      2:       return "free_list";
      3:       return "map";
      4:       return "double_free";
      5:       return "bad_ckpt";
      6:       return "ckpt_overflow";
      default: return "unknown";
    endcase
  endfunction

  // Report every flagged bit and stop at the offending edge.
  always_ff @(posedge clock) begin
    if (!reset && (err_s != 7'd0)) begin
      for (int b = 0; b < 7; b++) begin
        if (err_s[b]) begin
          $error("dispatch_checker: err[%0d] %s lane %0d", b, err_name(b), err_lane_s);
        end
      end
      $finish;
    end
  end
`endif
endmodule
